// File: rtl/op_tree_pkg.sv
// Shared helpers for the pipelined operand-reduction tree (op_tree_pipe).
//   clog2   : number of pairwise-adder levels needed for n operands
//   sum_w   : full-precision sum width (operand width + one bit per level)
//   sat_hi  : largest value representable in ow bits (bit pattern)
//   sat_lo  : smallest value representable in ow bits (bit pattern)
package op_tree_pkg;

  function automatic int clog2(input int unsigned n);
    int          r;
    int unsigned v;
    r = 0;
    v = n - 1;
    while (v != 0) begin
      v = v >> 1;
      r++;
    end
    return r;
  endfunction

  function automatic int sum_w(input int dw, input int levels);
    return dw + levels;
  endfunction

  function automatic logic [63:0] sat_hi(input int ow, input bit sgn);
    if (sgn) return (64'd1 << (ow - 1)) - 64'd1;
    else     return (64'd1 << ow) - 64'd1;
  endfunction

  // Two's-complement pattern of -2^(ow-1) in the low ow bits, or zero.
  function automatic logic [63:0] sat_lo(input int ow, input bit sgn);
    if (sgn) return 64'd1 << (ow - 1);
    else     return 64'd0;
  endfunction

endpackage

// File: rtl/op_tree_pipe_level.sv
// One registered level of the reduction tree: N operands of W bits are
// summed pairwise into N/2 results of W+1 bits (sign- or zero-extended).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   valid_i      upstream level holds a valid vector
//   din_i        N packed operands, operand k at [k*W +: W]
//   load_down_i  next stage loads this cycle (frees this register)
//   load_o       this level loads this cycle (upstream is consumed)
//   valid_o      this level holds a valid vector
//   dout_o       N/2 packed sums, sum k at [k*(W+1) +: W+1]
module op_tree_level #(
  parameter int N      = 2,
  parameter int W      = 8,
  parameter int SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_i,
  input  logic [N*W-1:0]         din_i,
  input  logic                   load_down_i,
  output logic                   load_o,
  output logic                   valid_o,
  output logic [(N/2)*(W+1)-1:0] dout_o
);

  logic                   v_q;
  logic [(N/2)*(W+1)-1:0] d_q, d_d;

  function automatic logic [W:0] ext(input logic [W-1:0] x);
    return {((SIGNED != 0) & x[W-1]), x};
  endfunction

  // An empty register always loads; a full one only when its content moves on.
  assign load_o  = ~v_q | load_down_i;
  assign valid_o = v_q;
  assign dout_o  = d_q;

  always_comb begin
    d_d = '0;
    for (int unsigned k = 0; k < N / 2; k++) begin
      d_d[k*(W+1) +: (W+1)] = ext(din_i[2*k*W +: W]) + ext(din_i[(2*k+1)*W +: W]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else if (load_o) begin
      v_q <= valid_i;
      if (valid_i) d_q <= d_d;
    end
  end

endmodule

// File: rtl/op_tree_pipe.sv
// Pipelined N_IN-operand adder tree with floor right shift by SHIFT, trim to
// OW bits and overflow flag. One register per tree level plus an output
// register; valid/ready on both sides with bubble-collapsing stalls.
// Optional macro OP_TREE_PIPE_SAT_EN: clamp overflowed results to the nearest
// OW-bit limit instead of wrapping (out_ovf is produced either way).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   in_valid     input vector valid
//   in_ready     a vector is accepted this cycle when in_valid is high
//   in_data      N_IN packed operands, operand k at [k*DW +: DW]
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   out_data     shifted, trimmed (or clamped) sum
//   out_ovf      shifted sum did not fit in OW bits
module op_tree_pipe
  import op_tree_pkg::*;
#(
  parameter int N_IN   = 16,
  parameter int DW     = 12,
  parameter int SHIFT  = 3,
  parameter int OW     = 12,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN*DW-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OW-1:0]     out_data,
  output logic              out_ovf
);

  localparam int LEVELS = clog2(N_IN);
  localparam int NP     = 1 << LEVELS;
  localparam int SW     = sum_w(DW, LEVELS);
  // One spare bit above both SW and OW keeps the range checks uniform.
  localparam int XW     = ((SW > OW) ? SW : OW) + 1;

  logic [NP*DW-1:0]   pad;
  logic [LEVELS:0]    vld;
  logic [LEVELS+1:1]  ld;
  logic [SW-1:0]      sum;

  always_comb begin
    pad = '0;
    pad[N_IN*DW-1:0] = in_data;
  end

  assign vld[0] = in_valid;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NI = NP >> l;
    localparam int WI = DW + l;
    logic [NI*WI-1:0]         din;
    logic [(NI/2)*(WI+1)-1:0] dout;
    if (l == 0) begin : g_first
      assign din = pad;
    end else begin : g_next
      assign din = g_lvl[l-1].dout;
    end
    op_tree_level #(
      .N      (NI),
      .W      (WI),
      .SIGNED (SIGNED)
    ) u_level (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_i     (vld[l]),
      .din_i       (din),
      .load_down_i (ld[l+2]),
      .load_o      (ld[l+1]),
      .valid_o     (vld[l+1]),
      .dout_o      (dout)
    );
  end

  assign sum = g_lvl[LEVELS-1].dout;

  logic          ext_bit;
  logic [XW-1:0] sx, s_sh;
  logic [OW-1:0] data_d;
  logic          ovf_d;

`ifdef OP_TREE_PIPE_SAT_EN
  localparam logic [OW-1:0] LIM_HI = OW'(sat_hi(OW, SIGNED != 0));
  localparam logic [OW-1:0] LIM_LO = OW'(sat_lo(OW, SIGNED != 0));
`endif

  always_comb begin
    ext_bit = (SIGNED != 0) & sum[SW-1];
    sx      = {{(XW-SW){ext_bit}}, sum};
    // Unsigned sums are zero-extended, so >>> degenerates to a logical shift.
    s_sh    = $signed(sx) >>> SHIFT;
    if (SIGNED != 0) ovf_d = !((&s_sh[XW-1:OW-1]) | ~(|s_sh[XW-1:OW-1]));
    else             ovf_d = |s_sh[XW-1:OW];
    data_d  = s_sh[OW-1:0];
`ifdef OP_TREE_PIPE_SAT_EN
    if (ovf_d) data_d = ((SIGNED != 0) && s_sh[XW-1]) ? LIM_LO : LIM_HI;
`endif
  end

  logic          vo_q, ovf_q, ld_out;
  logic [OW-1:0] data_q;

  assign ld_out        = ~vo_q | out_ready;
  assign ld[LEVELS+1]  = ld_out;
  assign in_ready      = rst_n & ld[1];
  assign out_valid     = vo_q;
  assign out_data      = data_q;
  assign out_ovf       = ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vo_q   <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else if (ld_out) begin
      vo_q <= vld[LEVELS];
      if (vld[LEVELS]) begin
        data_q <= data_d;
        ovf_q  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_op_tree_pipe.sv
module tb_op_tree_pipe;

`ifdef OP_TREE_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [11:0] d;
    logic        o;
  } exp_t;

  typedef struct {
    string        nm;
    int           which;
    logic [191:0] d;
    logic [11:0]  ed;
    logic         eo;
    int           lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // a: defaults, b: SIGNED=1, c: N_IN=5 DW=8 SHIFT=0 OW=11
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [191:0] a_in_data;
  logic [11:0]  a_out_data;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [191:0] b_in_data;
  logic [11:0]  b_out_data;
  logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf;
  logic [39:0]  c_in_data;
  logic [10:0]  c_out_data;

  op_tree_pipe #(.N_IN(16), .DW(12), .SHIFT(3), .OW(12), .SIGNED(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_ovf(a_out_ovf));

  op_tree_pipe #(.N_IN(16), .DW(12), .SHIFT(3), .OW(12), .SIGNED(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ovf(b_out_ovf));

  op_tree_pipe #(.N_IN(5), .DW(8), .SHIFT(0), .OW(11), .SIGNED(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_ovf(c_out_ovf));

  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Reference: integer sum of the operands, floor shift, range check, wrap or clamp.
  function automatic exp_t model(input int n, input int dw, input int sh, input int ow,
                                 input int sgn, input logic [191:0] data);
    longint s, op, sv, lo, hi;
    exp_t   e;
    s = 0;
    for (int k = 0; k < n; k++) begin
      op = 0;
      for (int b = 0; b < dw; b++) op[b] = data[k*dw+b];
      if (sgn != 0 && data[k*dw+dw-1]) op = op - (longint'(1) << dw);
      s = s + op;
    end
    sv = s >>> sh;
    lo = (sgn != 0) ? -(longint'(1) << (ow - 1)) : 0;
    hi = (sgn != 0) ? (longint'(1) << (ow - 1)) - 1 : (longint'(1) << ow) - 1;
    e.o = (sv < lo) || (sv > hi);
    if (SAT) begin
      if (sv < lo) sv = lo;
      else if (sv > hi) sv = hi;
    end
    e.d = '0;
    for (int b = 0; b < ow; b++) e.d[b] = sv[b];
    return e;
  endfunction

  function automatic logic [191:0] rep(input int dw, input int val, input int cnt);
    logic [191:0] r;
    r = '0;
    for (int k = 0; k < cnt; k++) r = r | (192'(val & ((1 << dw) - 1)) << (k * dw));
    return r;
  endfunction

  function automatic logic [191:0] put(input logic [191:0] d, input int dw, input int k, input int val);
    logic [191:0] m;
    m = 192'((1 << dw) - 1) << (k * dw);
    return (d & ~m) | ((192'(val) << (k * dw)) & m);
  endfunction

  function automatic vec_t mk(input string nm, input int which, input logic [191:0] d,
                              input logic [11:0] ed, input logic eo);
    vec_t t;
    t.nm = nm; t.which = which; t.d = d; t.ed = ed; t.eo = eo;
    t.lat = (which == 2) ? 4 : 5;
    return t;
  endfunction

  function automatic logic [191:0] bpv(input int i);
    logic [191:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k*12 +: 12] = 12'(i * 200 + k * 13);
    return r;
  endfunction

  function automatic logic [191:0] rnd_vec();
    logic [191:0] r;
    int           mode;
    mode = $urandom_range(0, 2);
    for (int k = 0; k < 16; k++) begin
      case (mode)
        0:       r[k*12 +: 12] = 12'($urandom);
        1:       r[k*12 +: 12] = 12'(4095 - $urandom_range(0, 15));
        default: r[k*12 +: 12] = 12'($urandom_range(0, 255));
      endcase
    end
    return r;
  endfunction

  function automatic logic cur_valid(input int which);
    case (which)
      0:       return a_out_valid;
      1:       return b_out_valid;
      default: return c_out_valid;
    endcase
  endfunction

  // Scoreboard for DUT a: every visible output is checked against the oldest
  // outstanding expectation, including repeatedly while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (q.size() == 0) begin
        chk("a_spurious_valid", a_out_valid, 0);
      end else if (a_out_valid) begin
        chk("a_data", a_out_data, q[0].d);
        chk("a_ovf", a_out_ovf, q[0].o);
        if (a_out_ready) begin
          void'(q.pop_front());
          n_out++;
        end
      end
      if (a_in_valid && a_in_ready) q.push_back(model(16, 12, 3, 12, 0, a_in_data));
    end
  end

  // Latency counts edges from the accepting edge inclusive.
  task automatic run_vec(input int which, input logic [191:0] d, output exp_t got, output int lat);
    case (which)
      0:       begin a_in_data = d; a_in_valid = 1'b1; end
      1:       begin b_in_data = d; b_in_valid = 1'b1; end
      default: begin c_in_data = d[39:0]; c_in_valid = 1'b1; end
    endcase
    @(posedge clk); #1;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    lat = 1;
    while (!cur_valid(which) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    case (which)
      0:       begin got.d = a_out_data; got.o = a_out_ovf; end
      1:       begin got.d = b_out_data; got.o = b_out_ovf; end
      default: begin got.d = {1'b0, c_out_data}; got.o = c_out_ovf; end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "simulation did not complete");
  end

  initial begin
    vec_t tbl[$];
    exp_t got;
    int   lat, sent, n0, nacc;
    logic acc;

    rst_n = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    a_in_data = '0; b_in_data = '0; c_in_data = '0;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_a_out_ovf", a_out_ovf, 0);
    chk("rst_a_in_ready", a_in_ready, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_c_out_valid", c_out_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_a_in_ready", a_in_ready, 1);

    tbl.push_back(mk("a_ones", 0, rep(12, 1, 16), 12'd2, 1'b0));
    tbl.push_back(mk("a_max", 0, rep(12, 4095, 16), SAT ? 12'd4095 : 12'd4094, 1'b1));
    tbl.push_back(mk("a_zero", 0, '0, 12'd0, 1'b0));
    tbl.push_back(mk("a_floor", 0, put('0, 12, 0, 7), 12'd0, 1'b0));
    tbl.push_back(mk("a_fit", 0, put(rep(12, 4095, 8), 12, 8, 7), 12'd4095, 1'b0));
    tbl.push_back(mk("a_over", 0, put(rep(12, 4095, 8), 12, 8, 8), SAT ? 12'd4095 : 12'd0, 1'b1));
    tbl.push_back(mk("b_neg8", 1, put('0, 12, 0, 'hFF8), 12'hFFF, 1'b0));
    tbl.push_back(mk("b_min_all", 1, rep(12, 'h800, 16), SAT ? 12'h800 : 12'h000, 1'b1));
    tbl.push_back(mk("b_min_fit", 1, rep(12, 'h800, 8), 12'h800, 1'b0));
    tbl.push_back(mk("b_max_fit", 1, rep(12, 'h7FF, 8), 12'h7FF, 1'b0));
    tbl.push_back(mk("b_max_over", 1, put(rep(12, 'h7FF, 8), 12, 8, 8), SAT ? 12'h7FF : 12'h800, 1'b1));
    tbl.push_back(mk("c_all255", 2, rep(8, 255, 5), 12'd1275, 1'b0));
    tbl.push_back(mk("c_last", 2, put('0, 8, 4, 255), 12'd255, 1'b0));

    foreach (tbl[i]) begin
      run_vec(tbl[i].which, tbl[i].d, got, lat);
      chk({tbl[i].nm, "_data"}, got.d, tbl[i].ed);
      chk({tbl[i].nm, "_ovf"}, got.o, tbl[i].eo);
      chk({tbl[i].nm, "_lat"}, lat, tbl[i].lat);
      repeat (2) @(posedge clk);
      #1;
    end

    // Backpressure: fill the pipe with the output stalled, then drain.
    n0 = n_out;
    a_out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      a_in_valid = (sent < 7);
      a_in_data  = bpv(sent);
      @(negedge clk);
      acc = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    chk("bp_accepts", sent, 5);
    chk("bp_in_ready_low", a_in_ready, 0);
    a_out_ready = 1'b1;
    for (int c = 0; c < 40 && (sent < 7 || q.size() != 0); c++) begin
      a_in_valid = (sent < 7);
      a_in_data  = bpv(sent);
      @(negedge clk);
      acc = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    a_in_valid = 1'b0;
    chk("bp_sent", sent, 7);
    chk("bp_drained", q.size(), 0);
    chk("bp_count", n_out - n0, 7);

    // Reset with three vectors in flight.
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = bpv(10 + i);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst6_out_valid", a_out_valid, 0);
    chk("rst6_in_ready", a_in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rst6_in_ready_rel", a_in_ready, 1);
    n0 = n_out;
    repeat (10) @(posedge clk);
    #1;
    chk("rst6_no_stale", n_out - n0, 0);
    chk("rst6_out_valid_late", a_out_valid, 0);

    // Random traffic with random backpressure; source holds data until accepted.
    n0 = n_out;
    nacc = 0;
    acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!a_in_valid || acc) begin
        a_in_valid = ($urandom_range(0, 3) != 0);
        a_in_data  = rnd_vec();
      end
      a_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = a_in_valid && a_in_ready;
      if (acc) nacc++;
      @(posedge clk); #1;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    for (int c = 0; c < 30 && q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    chk("rnd_drained", q.size(), 0);
    chk("rnd_count", n_out - n0, nacc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
